// File: rtl/vdc_angle_sequencer.sv
// Van der Corput angle sequencer feeding the 16-bit CORDIC stage.
// Folds angles into the convergent half-plane and queues un-folded points.
module vdc_angle_sequencer #(
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        seed_load,
  input  logic [15:0] seed,
  output logic        cordic_start,
  output logic [15:0] cordic_angle,
  input  logic        cordic_ready,
  input  logic        cordic_done,
  input  logic [31:0] cordic_cos,
  input  logic [31:0] cordic_sin,
  output logic        pt_valid,
  input  logic        pt_ready,
  output logic [31:0] pt_cos,
  output logic [31:0] pt_sin,
  output logic [15:0] pt_index,
  output logic        busy
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int AW = $clog2(DEPTH);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  typedef struct packed {
    logic [31:0] c;
    logic [31:0] s;
    logic [15:0] idx;
  } pt_t;

  state_t      state;
  logic [15:0] k;
  logic        flip_q;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nxt;
  logic [AW-1:0] widx;
  pt_t         mem [DEPTH];

  logic [15:0] k_nxt;
  logic [15:0] a_nxt;
  logic        flip_nxt;
  logic [15:0] ang_nxt;
  logic        can_issue;
  logic        flush;
  logic        push;
  logic        pop;
  pt_t         res;

  function automatic logic [15:0] bitrev16(input logic [15:0] v);
    logic [15:0] r;
    for (int i = 0; i < 16; i++) r[i] = v[15-i];
    return r;
  endfunction

  // Quadrants 1 and 2 are rotated by pi so the CORDIC sees |angle| <= pi/2.
  always_comb begin
    k_nxt    = k + 16'd1;
    a_nxt    = bitrev16(k_nxt);
    flip_nxt = a_nxt[15] ^ a_nxt[14];
    ang_nxt  = flip_nxt ? a_nxt + 16'h8000 : a_nxt;
  end

  assign can_issue = (state == S_IDLE) && !seed_load && enable &&
                     cordic_ready && (cnt < DEPTH_C);
  assign flush = (state == S_IDLE) && seed_load;
  assign push  = (state == S_WAIT) && cordic_done;
  assign pop   = pt_valid && pt_ready;

  always_comb begin
    res.c   = flip_q ? (~cordic_cos + 32'd1) : cordic_cos;
    res.s   = flip_q ? (~cordic_sin + 32'd1) : cordic_sin;
    res.idx = k;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= S_IDLE;
      k            <= 16'd0;
      flip_q       <= 1'b0;
      cordic_start <= 1'b0;
      cordic_angle <= 16'd0;
      busy         <= 1'b0;
    end else begin
      cordic_start <= 1'b0;
      case (state)
        S_IDLE: begin
          if (seed_load) begin
            k <= seed;
          end else if (can_issue) begin
            k            <= k_nxt;
            flip_q       <= flip_nxt;
            cordic_angle <= ang_nxt;
            cordic_start <= 1'b1;
            busy         <= 1'b1;
            state        <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (cordic_done) begin
            busy  <= 1'b0;
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    cnt_nxt = cnt;
    if (push && !pop) cnt_nxt = cnt + 1'b1;
    else if (pop && !push) cnt_nxt = cnt - 1'b1;
    widx = pop ? AW'(cnt - 1'b1) : AW'(cnt);
  end

  // Shift-register FIFO: the head always sits in mem[0], so pt_* are flops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt      <= '0;
      pt_valid <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      cnt      <= '0;
      pt_valid <= 1'b0;
    end else begin
      cnt      <= cnt_nxt;
      pt_valid <= (cnt_nxt != '0);
      if (pop) begin
        for (int i = 0; i < DEPTH - 1; i++) mem[i] <= mem[i+1];
      end
      if (push) mem[widx] <= res;
    end
  end

  assign pt_cos   = mem[0].c;
  assign pt_sin   = mem[0].s;
  assign pt_index = mem[0].idx;

endmodule

// File: tb/tb_vdc_angle_sequencer.sv
// Bench for vdc_angle_sequencer: randomized CORDIC latency/noise and
// consumer stalls, checked against ideal cos/sin of the van der Corput angle.
module tb_vdc_angle_sequencer;

  localparam real PI = 3.14159265358979;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b0;
  logic        seed_load = 1'b0;
  logic [15:0] seed = 16'd0;
  logic        cordic_start;
  logic [15:0] cordic_angle;
  logic        cordic_ready = 1'b1;
  logic        cordic_done = 1'b0;
  logic [31:0] cordic_cos = 32'd0;
  logic [31:0] cordic_sin = 32'd0;
  logic        pt_valid;
  logic        pt_ready = 1'b0;
  logic [31:0] pt_cos;
  logic [31:0] pt_sin;
  logic [15:0] pt_index;
  logic        busy;

  int compared = 0;
  int mismatched = 0;
  bit model_en = 1'b1;
  logic [15:0] issued_k = 16'd0;
  logic [15:0] exp_k = 16'd0;
  logic [15:0] start_q[$];

  vdc_angle_sequencer #(.DEPTH(2)) dut (
    .clk(clk), .rst(rst), .enable(enable),
    .seed_load(seed_load), .seed(seed),
    .cordic_start(cordic_start), .cordic_angle(cordic_angle),
    .cordic_ready(cordic_ready), .cordic_done(cordic_done),
    .cordic_cos(cordic_cos), .cordic_sin(cordic_sin),
    .pt_valid(pt_valid), .pt_ready(pt_ready),
    .pt_cos(pt_cos), .pt_sin(pt_sin), .pt_index(pt_index),
    .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] bitrev(input logic [15:0] v);
    logic [15:0] r;
    for (int i = 0; i < 16; i++) r[i] = v[15-i];
    return r;
  endfunction

  // Angles in the left half-plane (quadrants 1, 2) are sent rotated by pi.
  function automatic logic [15:0] folded(input logic [15:0] a);
    int q;
    logic [15:0] r;
    q = int'(a) / 16384;
    r = a + 16'h8000;
    return (q == 1 || q == 2) ? r : a;
  endfunction

  function automatic int fx(input real x);
    return $rtoi(x >= 0.0 ? x * 65536.0 + 0.5 : x * 65536.0 - 0.5);
  endfunction

  // CORDIC stand-in: random latency, small noise, junk outside done.
  initial begin
    logic [15:0] ang;
    real th;
    forever begin
      @(posedge clk);
      #1;
      cordic_cos = $urandom;
      cordic_sin = $urandom;
      if (cordic_start && model_en) begin
        ang = cordic_angle;
        cordic_ready = 1'b0;
        repeat ($urandom_range(3, 17)) begin
          @(posedge clk);
          #1;
          cordic_cos = $urandom;
          cordic_sin = $urandom;
        end
        th = 2.0 * PI * real'(ang) / 65536.0;
        cordic_done = 1'b1;
        cordic_cos = 32'(fx($cos(th)) + $urandom_range(0, 6) - 3);
        cordic_sin = 32'(fx($sin(th)) + $urandom_range(0, 6) - 3);
        @(posedge clk);
        #1;
        cordic_done = 1'b0;
        cordic_ready = 1'b1;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (cordic_start) begin
        start_q.push_back(cordic_angle);
        issued_k = issued_k + 16'd1;
      end
    end
  end

  initial begin
    #3ms;
    $display("FAIL watchdog: got timeout, required finish");
    $fatal(1, "watchdog");
  end

  task automatic test_stream(input int n);
    logic [15:0] kk, a, ang;
    real th;
    int w, dc, ds;
    for (int i = 0; i < n; i++) begin
      w = 0;
      while (!pt_valid && w < 500) begin
        @(negedge clk);
        w++;
      end
      compared++;
      if (!pt_valid) begin
        $display("FAIL stream_wait: got pt_valid=0, required 1");
        mismatched++;
        return;
      end
      repeat ($urandom_range(0, 2)) @(negedge clk);
      kk = exp_k + 16'd1;
      a = bitrev(kk);
      th = 2.0 * PI * real'(a) / 65536.0;
      compared++;
      if (pt_index !== kk) begin
        $display("FAIL pt_index: got %h, required %h", pt_index, kk);
        mismatched++;
      end
      ang = (start_q.size() > 0) ? start_q.pop_front() : 16'hxxxx;
      compared++;
      if (ang !== folded(a)) begin
        $display("FAIL cordic_angle k=%h: got %h, required %h",
                 kk, ang, folded(a));
        mismatched++;
      end
      dc = $signed(pt_cos) - fx($cos(th));
      ds = $signed(pt_sin) - fx($sin(th));
      compared++;
      if (dc > 64 || dc < -64) begin
        $display("FAIL pt_cos k=%h: got %h, required ~%h",
                 kk, pt_cos, 32'(fx($cos(th))));
        mismatched++;
      end
      compared++;
      if (ds > 64 || ds < -64) begin
        $display("FAIL pt_sin k=%h: got %h, required ~%h",
                 kk, pt_sin, 32'(fx($sin(th))));
        mismatched++;
      end
      pt_ready = 1'b1;
      @(negedge clk);
      pt_ready = 1'b0;
      exp_k = kk;
    end
  endtask

  // Stop issuing, wait out any request, then re-seed to flush the FIFO.
  task automatic settle();
    int w;
    enable = 1'b0;
    pt_ready = 1'b0;
    w = 0;
    @(negedge clk);
    while (busy && w < 200) begin
      @(negedge clk);
      w++;
    end
    compared++;
    if (busy) begin
      $display("FAIL settle_busy: got 1, required 0");
      mismatched++;
    end
    seed = issued_k;
    seed_load = 1'b1;
    @(negedge clk);
    seed_load = 1'b0;
    @(negedge clk);
    start_q.delete();
    exp_k = issued_k;
    compared++;
    if (pt_valid !== 1'b0) begin
      $display("FAIL flush: got pt_valid=%b, required 0", pt_valid);
      mismatched++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    compared += 7;
    if (cordic_start !== 1'b0) begin
      $display("FAIL rst_start: got %b, required 0", cordic_start);
      mismatched++;
    end
    if (cordic_angle !== 16'd0) begin
      $display("FAIL rst_angle: got %h, required 0000", cordic_angle);
      mismatched++;
    end
    if (pt_valid !== 1'b0) begin
      $display("FAIL rst_valid: got %b, required 0", pt_valid);
      mismatched++;
    end
    if (pt_cos !== 32'd0) begin
      $display("FAIL rst_cos: got %h, required 0", pt_cos);
      mismatched++;
    end
    if (pt_sin !== 32'd0) begin
      $display("FAIL rst_sin: got %h, required 0", pt_sin);
      mismatched++;
    end
    if (pt_index !== 16'd0) begin
      $display("FAIL rst_index: got %h, required 0", pt_index);
      mismatched++;
    end
    if (busy !== 1'b0) begin
      $display("FAIL rst_busy: got %b, required 0", busy);
      mismatched++;
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_first_points();
    int w = 0;
    enable = 1'b1;
    while (start_q.size() == 0 && w < 50) begin
      @(negedge clk);
      w++;
    end
    compared++;
    if (start_q.size() == 0 || start_q[0] !== 16'h0000) begin
      $display("FAIL first_angle: got %0d starts, required angle 0000",
               start_q.size());
      mismatched++;
    end
    test_stream(3);
  endtask

  task automatic test_backpressure();
    logic [15:0] base;
    logic [31:0] sc, ss;
    logic [15:0] si;
    bit stable = 1'b1;
    settle();
    base = issued_k;
    enable = 1'b1;
    repeat (150) @(negedge clk);
    compared++;
    if (issued_k - base !== 16'd2) begin
      $display("FAIL bp_issued: got %0d, required 2", issued_k - base);
      mismatched++;
    end
    compared++;
    if (busy !== 1'b0) begin
      $display("FAIL bp_busy: got %b, required 0", busy);
      mismatched++;
    end
    sc = pt_cos;
    ss = pt_sin;
    si = pt_index;
    repeat (20) begin
      @(negedge clk);
      if (pt_cos !== sc || pt_sin !== ss || pt_index !== si || !pt_valid)
        stable = 1'b0;
    end
    compared++;
    if (!stable) begin
      $display("FAIL bp_stable: got changing head, required held");
      mismatched++;
    end
    test_stream(1);
    repeat (100) @(negedge clk);
    compared++;
    if (issued_k - base !== 16'd3) begin
      $display("FAIL bp_one_more: got %0d, required 3", issued_k - base);
      mismatched++;
    end
    test_stream(2);
  endtask

  task automatic test_seed_wrap();
    settle();
    enable = 1'b1;
    repeat (100) @(negedge clk);
    enable = 1'b0;
    repeat (40) @(negedge clk);
    compared++;
    if (pt_valid !== 1'b1) begin
      $display("FAIL wrap_prefill: got pt_valid=%b, required 1", pt_valid);
      mismatched++;
    end
    seed = 16'hFFFE;
    seed_load = 1'b1;
    @(negedge clk);
    seed_load = 1'b0;
    compared++;
    if (pt_valid !== 1'b0) begin
      $display("FAIL wrap_flush: got pt_valid=%b, required 0", pt_valid);
      mismatched++;
    end
    start_q.delete();
    issued_k = 16'hFFFE;
    exp_k = 16'hFFFE;
    enable = 1'b1;
    test_stream(2);
  endtask

  task automatic test_seed_in_wait();
    int w = 0;
    settle();
    enable = 1'b1;
    while (!busy && w < 50) begin
      @(negedge clk);
      w++;
    end
    seed = 16'h1234;
    seed_load = 1'b1;
    @(negedge clk);
    seed_load = 1'b0;
    compared++;
    if (busy !== 1'b1) begin
      $display("FAIL seed_wait_busy: got %b, required 1", busy);
      mismatched++;
    end
    test_stream(2);
  endtask

  task automatic test_reset_in_wait();
    int w = 0;
    settle();
    model_en = 1'b0;
    enable = 1'b1;
    while (!cordic_start && w < 50) begin
      @(negedge clk);
      w++;
    end
    @(negedge clk);
    #1;
    rst = 1'b1;
    #1;
    compared++;
    if (busy !== 1'b0 || cordic_start !== 1'b0 || cordic_angle !== 16'd0 ||
        pt_valid !== 1'b0 || pt_index !== 16'd0) begin
      $display("FAIL async_rst: got busy=%b start=%b angle=%h, required 0",
               busy, cordic_start, cordic_angle);
      mismatched++;
    end
    enable = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    cordic_done = 1'b1;
    @(negedge clk);
    cordic_done = 1'b0;
    repeat (3) @(negedge clk);
    compared++;
    if (pt_valid !== 1'b0 || busy !== 1'b0) begin
      $display("FAIL stray_done: got valid=%b busy=%b, required 0 0",
               pt_valid, busy);
      mismatched++;
    end
    start_q.delete();
    issued_k = 16'd0;
    exp_k = 16'd0;
    model_en = 1'b1;
    enable = 1'b1;
    test_stream(1);
    enable = 1'b0;
  endtask

  initial begin
    test_reset();
    test_first_points();
    test_stream(6);
    test_backpressure();
    test_seed_wrap();
    test_seed_in_wait();
    test_reset_in_wait();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule
